axil_sram_slave: RTL



---
 rtl/axil_sram_slave.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/axil_sram_slave.sv
// AXI4-Lite SRAM responder: one transaction in flight, fixed response latency, DECERR outside its window.
// Define AXIL_SRAM_RAND_DELAY_EN to add 0..7 extra LFSR-driven wait cycles per transaction.
module axil_sram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

    state_t        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d, cnt_load;
    logic [AW-1:0] idx_q, idx_d;
    logic          in_rng_q, in_rng_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          last_wr_q, last_wr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d, bresp_q, bresp_d;
    logic          rvalid_q, rvalid_d, bvalid_q, bvalid_d;
    logic          mem_we;
    logic [31:0]   mem [DEPTH];

    logic          grant_wr, grant_rd;
    logic [31:0]   dec_off;
    logic          dec_in_rng;
    logic [AW-1:0] dec_idx;

    // On a tie the grant goes to whichever side did not win last time.
    assign grant_wr = (state_q == IDLE) && awvalid && wvalid && (!arvalid || !last_wr_q);
    assign grant_rd = (state_q == IDLE) && arvalid && !grant_wr;

    assign arready = (state_q == IDLE) && !grant_wr;
    assign awready = grant_wr;
    assign wready  = grant_wr;

    // Addresses below the base wrap to a huge offset, so one unsigned compare covers both bounds.
    assign dec_off    = (grant_wr ? awaddr : araddr) - BASE_ADDR;
    assign dec_in_rng = {1'b0, dec_off} < SPAN;
    assign dec_idx    = dec_off[AW+1:2];

`ifdef AXIL_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr_q, lfsr_d;
    assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign cnt_load = 5'(LATENCY) + {2'b00, lfsr_q[2:0]};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 8'hA5;
        else     lfsr_q <= lfsr_d;
    end
`else
    assign cnt_load = 5'(LATENCY);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        in_rng_d  = in_rng_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        last_wr_d = last_wr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        bvalid_d  = bvalid_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_wr || grant_rd) begin
                    last_wr_d = grant_wr;
                    idx_d     = dec_idx;
                    in_rng_d  = dec_in_rng;
                    cnt_d     = cnt_load;
                end
                if (grant_wr) begin
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                    state_d = (cnt_load == '0) ? WR_RESP : WR_WAIT;
                end else if (grant_rd) begin
                    state_d = (cnt_load == '0) ? RD_RESP : RD_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q <= 5'd1) state_d = (state_q == RD_WAIT) ? RD_RESP : WR_RESP;
            end
            // First cycle in a response state produces the response; later cycles wait for ready.
            RD_RESP: begin
                if (!rvalid_q) begin
                    rvalid_d = 1'b1;
                    rdata_d  = in_rng_q ? mem[idx_q] : '0;
                    rresp_d  = in_rng_q ? RESP_OKAY : RESP_DECERR;
                end else if (rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            WR_RESP: begin
                if (!bvalid_q) begin
                    bvalid_d = 1'b1;
                    bresp_d  = in_rng_q ? RESP_OKAY : RESP_DECERR;
                    mem_we   = in_rng_q;
                end else if (bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            in_rng_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            last_wr_q <= 1'b1;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            in_rng_q  <= in_rng_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            last_wr_q <= last_wr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            bvalid_q  <= bvalid_d;
        end
    end

    // Storage is deliberately not reset; a write pending at reset never reaches it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign rvalid = rvalid_q;
    assign bresp  = bresp_q;
    assign bvalid = bvalid_q;
endmodule
